// File: rtl/xbar_slave_resp_router_pkg.sv
// Shared crossbar definitions: master count, master-index type and the
// one-hot decoder used by both the grant path and the response path.
package xbar_slave_resp_router_pkg;

  // Number of masters on the cluster crossbar and the width of their index.
  localparam int XBAR_NUM_INPUT = 3;
  localparam int XBAR_SEL_WIDTH = (XBAR_NUM_INPUT > 1) ? $clog2(XBAR_NUM_INPUT) : 1;

  typedef logic [XBAR_SEL_WIDTH-1:0] mst_idx_t;
  typedef logic [XBAR_NUM_INPUT-1:0] mst_vec_t;

  // Decode a master index into a one-hot vector qualified by en. An index
  // outside the master range decodes to all zeros, so a stray select can
  // never raise a grant or a response valid.
  function automatic mst_vec_t to_onehot(mst_idx_t idx, logic en);
    mst_vec_t oh;
    oh = '0;
    for (int i = 0; i < XBAR_NUM_INPUT; i++) begin
      if (en && (int'(idx) == i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/xbar_id_fifo.sv
// In-order ID FIFO. Remembers which master owns each granted, unanswered
// slave transaction. Occupancy lives in its own counter; full and empty are
// derived from that counter, never from pointer equality.
module xbar_id_fifo #(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Storage write for each accepted push.
  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // read after it has been written, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two, so the
  // pointers wrap by natural overflow.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= CNT_W'(DEPTH));

endmodule

// File: rtl/xbar_slave_resp_router.sv
// Per-slave return path of the cluster crossbar. Forwards the selected
// master's request to the slave, steers the grant back to that master,
// records its index in an in-order ID FIFO and routes every slave response
// to the master at the FIFO head with zero added latency.
module xbar_slave_resp_router
  import xbar_slave_resp_router_pkg::*;
#(
  // NUM_INPUT must match the crossbar-wide master count in the package,
  // since the shared one-hot decoder is sized from it.
  parameter int NUM_INPUT       = XBAR_NUM_INPUT,
  parameter int SEL_WIDTH       = $clog2(NUM_INPUT),
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic                  en_i,
  output logic                  slv_req_o,
  input  logic                  slv_gnt_i,
  output logic [NUM_INPUT-1:0]  mst_gnt_o,
  input  logic                  slv_r_valid_i,
  input  logic [DATA_WIDTH-1:0] slv_r_rdata_i,
  output logic [NUM_INPUT-1:0]  mst_r_valid_o,
  output logic [DATA_WIDTH-1:0] mst_r_rdata_o,
  output logic [CNT_WIDTH-1:0]  outstanding_o,
  output logic                  err_o
);

  logic     sel_valid;
  logic     push;
  logic     resp_ok;
  logic     fifo_full;
  logic     fifo_empty;
  mst_idx_t head;

  // A full FIFO blocks the request outright, even when a response pops an
  // entry in the same cycle; this keeps slv_r_valid_i off the request path.
  assign sel_valid = (int'(sel_i) < NUM_INPUT);
  assign slv_req_o = en_i & ~fifo_full & sel_valid;
  assign push      = slv_req_o & slv_gnt_i;
  assign mst_gnt_o = to_onehot(sel_i, push);

  // Responses return in order, so the FIFO head always names their owner.
  // A response at count 0 is a protocol error; a same-cycle new ID is never
  // bypassed to it.
  assign resp_ok       = slv_r_valid_i & ~fifo_empty;
  assign mst_r_valid_o = to_onehot(head, resp_ok);
  assign mst_r_rdata_o = slv_r_rdata_i;

  xbar_id_fifo #(
    .WIDTH (SEL_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (slv_r_valid_i),
    .wdata (sel_i),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding_o)
  );

  // Sticky error flag: set by a response with no transaction outstanding,
  // cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if (slv_r_valid_i && fifo_empty) begin
      err_o <= 1'b1;
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(mst_gnt_o));

  a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(mst_r_valid_o));

endmodule

// File: doc/xbar_slave_resp_router.md
Name: xbar_slave_resp_router

Overview:
- Return-path companion to the per-slave master selector in the cluster crossbar.
- Accepts the selector's chosen master index and enable for one slave port, drives that slave's request, and returns the grant to the chosen master.
- Records the master index of every granted transaction in an in-order ID FIFO; steers each slave response (r_valid/r_rdata) back to the originating master.
- One instance per slave port (e.g. HWCE or TCDM bank).

Parameters:
NUM_INPUT, 3, number of masters competing for this slave
SEL_WIDTH, $clog2(NUM_INPUT), width of master index
DATA_WIDTH, 32, response data width
MAX_OUTSTANDING, 4, ID FIFO depth (power of two, >=2)
CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), outstanding-counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
sel_i  in  SEL_WIDTH  master index from the master selector
en_i  in  1  a master addresses this slave this cycle
slv_req_o  out  1  request to slave
slv_gnt_i  in  1  slave grant
mst_gnt_o  out  NUM_INPUT  one-hot grant back to masters
slv_r_valid_i  in  1  slave response valid (in order, >=1 cycle after grant)
slv_r_rdata_i  in  DATA_WIDTH  slave response data
mst_r_valid_o  out  NUM_INPUT  one-hot response valid to masters
mst_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all masters
outstanding_o  out  CNT_WIDTH  number of granted, unanswered transactions
err_o  out  1  sticky: response arrived with empty ID FIFO

Behaviour:
- Reset, async on rst_n low:
  - FIFO pointers = 0; count = 0; err_o = 0.
  - All combinational outputs then evaluate to 0 (FIFO empty, count 0).
- full = (count == MAX_OUTSTANDING), taken from the registered count.
- Request and grant, combinational:
  - slv_req_o = en_i & ~full.
  - mst_gnt_o[sel_i] = slv_gnt_i & slv_req_o; all other bits 0.
  - sel_i >= NUM_INPUT: slv_req_o = 0 and no grant issued.
- Push: on clk edge with slv_req_o & slv_gnt_i, write sel_i at wr_ptr; wr_ptr wraps modulo MAX_OUTSTANDING.
- Full: no request is issued, even if a pop occurs the same cycle. This is a conservative decision that avoids a combinational path from slv_r_valid_i to slv_req_o.
- Response, zero added latency, combinational:
  - head = fifo[rd_ptr].
  - mst_r_valid_o[head] = slv_r_valid_i & ~empty; all other bits 0.
  - mst_r_rdata_o = slv_r_rdata_i.
- Pop: on clk edge with slv_r_valid_i & ~empty, rd_ptr advances and wraps.
- Simultaneous push and pop (count not full): count unchanged; both pointers advance.
- Same-cycle grant and response when count = 0: the response is erroneous. The slave protocol forbids this; the new ID is not bypassed.
- slv_r_valid_i with empty FIFO: no master valid asserted; err_o set to 1 on the next edge and held until reset.
- count: +1 on push only, -1 on pop only; never exceeds MAX_OUTSTANDING, never below 0.
- outstanding_o = count.
- No state machine beyond the FIFO. Pointers are SEL-indexed storage with a separate count register; full/empty are not derived from pointer equality.
- Assertions (sim only):
  - mst_gnt_o and mst_r_valid_o are each $onehot0.
  - count <= MAX_OUTSTANDING.

Decomposition:
- Shared crossbar package holds:
  - typedef for the master index (logic [SEL_WIDTH-1:0]);
  - a function to_onehot(idx, en) returning logic [NUM_INPUT-1:0], used by both grant and response paths.
- One natural sub-module: xbar_id_fifo (parameters WIDTH and DEPTH; push, pop, head, full, empty, count).
- The router instantiates xbar_id_fifo and adds grant and response steering.

Test Plan:
1. Reset mid-traffic:
   - Stimulus: 2 outstanding, assert rst_n = 0.
   - Response: immediately outstanding_o = 0, mst_r_valid_o = 0, err_o = 0. After release, a response with no request sets err_o = 1 one cycle later.
2. Single transaction:
   - Stimulus: sel_i = 2, en_i = 1, slv_gnt_i = 1 at cycle 0; slv_r_valid_i = 1 with rdata = 32'hDEAD_BEEF at cycle 1.
   - Response: mst_gnt_o = 3'b100 at cycle 0; mst_r_valid_o = 3'b100 with rdata DEAD_BEEF at cycle 1; outstanding_o 0 -> 1 -> 0.
3. In-order return:
   - Stimulus: grants to masters 1, 0, 2 on consecutive cycles; three responses follow.
   - Response: mst_r_valid_o = 010, 001, 100 in that order.
4. Full backpressure (MAX_OUTSTANDING = 4):
   - Stimulus: 4 grants with no responses, then en_i = 1.
   - Response: slv_req_o = 0, mst_gnt_o = 0. On a response that cycle, still no request; the request is accepted the next cycle.
5. Simultaneous push/pop at count 2:
   - Response: count stays 2; ID order preserved across rd_ptr/wr_ptr wrap after 10 such cycles.
6. Slave holds slv_gnt_i = 0:
   - Stimulus: en_i = 1, sel_i = 1 for 3 cycles.
   - Response: slv_req_o = 1, mst_gnt_o = 0, no push. Grant on cycle 4 yields mst_gnt_o = 010 and exactly one push.
